mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_pkg.sv | 17 +
 rtl/rr_arbiter2.sv | 20 ++
 rtl/mem_arbiter.sv | 114 +++++++++++
 tb/tb_mem_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types for the memory arbiter: FSM state encoding and port IDs.
// Imported by mem_arbiter and rr_arbiter2.
package mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RDWAIT = 2'd2,
    S_ACK    = 2'd3
  } state_t;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_LDR = 1'b1
  } port_id_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the
// port not granted last. Ports: req[1:0] (bit = port id), last, grant.
module rr_arbiter2
  import mem_pkg::*;
(
  input  logic [1:0] req,
  input  port_id_t   last,
  output port_id_t   grant
);

  always_comb begin
    grant = PORT_CPU;
    case (req)
      2'b10:   grant = PORT_LDR;
      2'b11:   grant = (last == PORT_CPU) ? PORT_LDR : PORT_CPU;
      default: grant = PORT_CPU;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between CPU and program loader.
// Ports: cpu_*/ldr_* request ports, rdata, ram_* RAM side, busy.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int AW = 9,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic          cpu_stall,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic          ldr_ack,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  input  logic [DW-1:0] ram_rdata,
  output logic          busy
);

  state_t        state_q, state_d;
  port_id_t      owner_q, owner_d;
  port_id_t      last_q, last_d;
  port_id_t      grant;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;

  rr_arbiter2 u_rr (
    .req   ({ldr_req, cpu_req}),
    .last  (last_q),
    .grant (grant)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      owner_q <= PORT_CPU;
      last_q  <= PORT_LDR;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (cpu_req || ldr_req) begin
          state_d = S_ACCESS;
          owner_d = grant;
          if (grant == PORT_LDR) begin
            we_d    = ldr_we;
            addr_d  = ldr_addr;
            wdata_d = ldr_wdata;
          end else begin
            we_d    = cpu_we;
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
          end
        end
      end
      S_ACCESS: state_d = we_q ? S_ACK : S_RDWAIT;
      S_RDWAIT: begin
        rdata_d = ram_rdata;
        state_d = S_ACK;
      end
      S_ACK: begin
        last_d  = owner_q;
        state_d = S_IDLE;
        // clearing here keeps the RAM bus at zero while idle
        we_d    = 1'b0;
        addr_d  = '0;
        wdata_d = '0;
      end
    endcase
  end

  assign ram_we    = (state_q == S_ACCESS) && we_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign rdata     = rdata_q;
  assign busy      = (state_q != S_IDLE);
  assign cpu_ack   = (state_q == S_ACK) && (owner_q == PORT_CPU);
  assign ldr_ack   = (state_q == S_ACK) && (owner_q == PORT_LDR);
  assign cpu_stall = cpu_req && !cpu_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a behavioural sync RAM.
// Table-driven single transactions plus hand-written corner sequences.
module tb_mem_arbiter;
  import mem_pkg::*;

  localparam int AW = 9;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we, cpu_ack, cpu_stall;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          ldr_req, ldr_we, ldr_ack;
  logic [AW-1:0] ldr_addr;
  logic [DW-1:0] ldr_wdata;
  logic [DW-1:0] rdata, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_we, busy;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr),
    .ldr_wdata(ldr_wdata), .ldr_ack(ldr_ack),
    .rdata(rdata), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_we(ram_we), .ram_rdata(ram_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] ram [2**AW];
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end

  typedef struct {
    logic          we;
    logic          cmp;
    logic [DW-1:0] data;
  } exp_t;

  typedef struct {
    port_id_t      p;
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] exp;
    int            lat;
  } vec_t;

  exp_t          sb_cpu[$];
  exp_t          sb_ldr[$];
  port_id_t      glog[$];
  logic [DW-1:0] ref_mem [2**AW];
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic txn(input port_id_t p, input logic we,
                     input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input logic [DW-1:0] exp, input logic cmp_w,
                     input int lat);
    exp_t e;
    int   n;
    logic got;
    logic ack;
    @(negedge clk);
    if (we) ref_mem[a] = d;
    e.we   = we;
    e.cmp  = !we || cmp_w;
    e.data = exp;
    if (p == PORT_CPU) begin
      sb_cpu.push_back(e);
      cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
    end else begin
      sb_ldr.push_back(e);
      ldr_we = we; ldr_addr = a; ldr_wdata = d; ldr_req = 1'b1;
    end
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      got = (p == PORT_CPU) ? cpu_ack : ldr_ack;
    end
    if (p == PORT_CPU) cpu_req = 1'b0;
    else ldr_req = 1'b0;
    chk("ack_timeout", {63'd0, got}, 64'd1);
    if (got) begin
      glog.push_back(p);
      if (p == PORT_CPU) e = sb_cpu.pop_front();
      else e = sb_ldr.pop_front();
      if (e.cmp) chk("rdata", rdata, e.data);
      if (lat > 0) chk("latency", n, lat);
      @(negedge clk);
      ack = (p == PORT_CPU) ? cpu_ack : ldr_ack;
      chk("ack_one_cycle", {63'd0, ack}, 64'd0);
    end
  endtask

  vec_t vecs[10];

  initial begin
    #500000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1);
  end

  initial begin
    int viol, lp, cp, cn, acks;
    vecs[0] = '{PORT_CPU, 1'b0, 9'h010, 32'h0, 32'hDEADBEEF, 3};
    vecs[1] = '{PORT_LDR, 1'b1, 9'h1FF, 32'hA5A5A5A5, 32'hDEADBEEF, 2};
    vecs[2] = '{PORT_LDR, 1'b0, 9'h1FF, 32'h0, 32'hA5A5A5A5, 3};
    vecs[3] = '{PORT_CPU, 1'b1, 9'h000, 32'h12345678, 32'hA5A5A5A5, 2};
    vecs[4] = '{PORT_LDR, 1'b0, 9'h000, 32'h0, 32'h12345678, 3};
    vecs[5] = '{PORT_CPU, 1'b1, 9'h001, 32'h11111111, 32'h12345678, 2};
    vecs[6] = '{PORT_LDR, 1'b1, 9'h002, 32'h22222222, 32'h12345678, 2};
    vecs[7] = '{PORT_CPU, 1'b0, 9'h1FF, 32'h0, 32'hA5A5A5A5, 3};
    vecs[8] = '{PORT_CPU, 1'b0, 9'h001, 32'h0, 32'h11111111, 3};
    vecs[9] = '{PORT_LDR, 1'b0, 9'h002, 32'h0, 32'h22222222, 3};

    rst = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    ldr_req = 0; ldr_we = 0; ldr_addr = '0; ldr_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_cpu_ack", cpu_ack, 0);
    chk("rst_ldr_ack", ldr_ack, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_ram_we", ram_we, 0);
    cpu_req = 1'b1;
    #1;
    chk("rst_stall", cpu_stall, 1);
    cpu_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // CPU write with cycle-by-cycle RAM bus checks
    @(negedge clk);
    cpu_we = 1; cpu_addr = 9'h010; cpu_wdata = 32'hDEADBEEF; cpu_req = 1;
    ref_mem[9'h010] = 32'hDEADBEEF;
    #1;
    chk("w_stall_idle", cpu_stall, 1);
    @(negedge clk);
    chk("w_access_we", ram_we, 1);
    chk("w_access_addr", ram_addr, 9'h010);
    chk("w_access_data", ram_wdata, 32'hDEADBEEF);
    chk("w_access_ack", cpu_ack, 0);
    chk("w_access_stall", cpu_stall, 1);
    @(negedge clk);
    chk("w_ack", cpu_ack, 1);
    chk("w_ack_we", ram_we, 0);
    chk("w_ack_addr", ram_addr, 9'h010);
    chk("w_ack_stall", cpu_stall, 0);
    chk("w_rdata_kept", rdata, 0);
    cpu_req = 0;
    @(negedge clk);
    chk("w_idle_busy", busy, 0);
    chk("w_idle_addr", ram_addr, 0);
    chk("w_idle_wdata", ram_wdata, 0);
    chk("w_idle_ack", cpu_ack, 0);

    foreach (vecs[i])
      txn(vecs[i].p, vecs[i].we, vecs[i].a, vecs[i].d,
          vecs[i].exp, 1'b1, vecs[i].lat);

    // loader stream against continuous CPU reads
    glog.delete();
    fork
      for (int i = 0; i < 16; i++)
        txn(PORT_LDR, 1'b1, AW'(i), 32'hC0DE0000 + i, 32'h0, 1'b0, 0);
      for (int j = 0; j < 16; j++)
        txn(PORT_CPU, 1'b0, j[0] ? 9'h1FF : 9'h010, 32'h0,
            ref_mem[j[0] ? 9'h1FF : 9'h010], 1'b0, 0);
    join
    chk("stream_count", glog.size(), 32);
    viol = 0;
    for (int k = 1; k < glog.size(); k++)
      if (glog[k] == glog[k-1]) viol++;
    chk("stream_alternate", viol, 0);
    for (int i = 0; i < 16; i++)
      txn(PORT_CPU, 1'b0, AW'(i), 32'h0, 32'hC0DE0000 + i, 1'b0, 3);

    // reset during RDWAIT
    @(negedge clk);
    cpu_we = 0; cpu_addr = 9'h010; cpu_req = 1;
    @(negedge clk);
    @(negedge clk);
    chk("rdwait_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_we", ram_we, 0);
    chk("midrst_rdata", rdata, 0);
    chk("midrst_ack", cpu_ack, 0);
    chk("midrst_stall", cpu_stall, 1);
    cpu_req = 0;
    @(negedge clk);
    rst = 1'b0;
    acks = 0;
    repeat (5) begin
      @(negedge clk);
      if (cpu_ack || ldr_ack) acks++;
    end
    chk("midrst_no_ack", acks, 0);
    chk("midrst_idle", busy, 0);

    // simultaneous pairs after reset: CPU first both times
    glog.delete();
    repeat (2)
      fork
        txn(PORT_CPU, 1'b0, 9'h001, 32'h0, ref_mem[1], 1'b0, 0);
        txn(PORT_LDR, 1'b0, 9'h002, 32'h0, ref_mem[2], 1'b0, 0);
      join
    chk("pair_count", glog.size(), 4);
    if (glog.size() == 4) begin
      chk("pair1_first", glog[0], PORT_CPU);
      chk("pair1_second", glog[1], PORT_LDR);
      chk("pair2_first", glog[2], PORT_CPU);
      chk("pair2_second", glog[3], PORT_LDR);
    end

    // loader drops req in ACCESS; pending CPU read served next
    @(negedge clk);
    ldr_we = 1; ldr_addr = 9'h050; ldr_wdata = 32'h0BADF00D; ldr_req = 1;
    @(negedge clk);
    ldr_req = 0;
    cpu_we = 0; cpu_addr = 9'h050; cpu_req = 1;
    lp = 0; cp = 0; cn = 0;
    for (int k = 2; k < 12; k++) begin
      @(negedge clk);
      if (ldr_ack) lp++;
      if (cpu_ack) begin
        cp++;
        cn = k;
        chk("drop_rdata", rdata, 32'h0BADF00D);
        cpu_req = 0;
      end
    end
    chk("drop_ldr_acks", lp, 1);
    chk("drop_cpu_acks", cp, 1);
    chk("drop_cpu_cycle", cn, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
